ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 151 +++++++++++++++
 tb/tb_ram_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port arbiter in front of a single-port synchronous RAM.
// Grants at most one access per cycle, with streaks capped at MAX_HOLD under
// contention. Reads return two cycles after the grant, to the issuing port.
// Optional feature macro: RAM_ARB_ROUND_ROBIN_EN (IDLE ties go to the port
// not granted most recently); undefined means IDLE ties always go to port 0.
module ram_arbiter #(
   parameter int AW       = 12,
   parameter int DW       = 16,
   parameter int MAX_HOLD = 8
) (
   input  logic          clock,
   input  logic          n_reset,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_data,
   output logic          m_wren,
   input  logic [DW-1:0] m_q
);

   localparam int STAGES = 2;
   localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } port_req_t;

   state_t          state, state_nx;
   logic [7:0]      hold, hold_nx, hold_inc;
   logic            grant, grant_port, tie_port, at_limit, rd_issue;
   port_req_t       preq0, preq1, sel;
   logic [STAGES:1] vld_pipe, port_pipe;
   logic [DW-1:0]   q_cap;

   assign preq0    = {we0, addr0, wdata0};
   assign preq1    = {we1, addr1, wdata1};
   assign sel      = grant_port ? preq1 : preq0;
   assign at_limit = (hold >= HOLD_LIM);
   // Saturate so a long sole-requester streak never wraps below the limit.
   assign hold_inc = (hold == 8'hFF) ? hold : hold + 8'd1;
   assign rd_issue = grant & ~sel.we;

`ifdef RAM_ARB_ROUND_ROBIN_EN
   logic last_port;

   // Remember the most recently granted port; reset value makes port 0 win first.
   always_ff @(posedge clock) begin
      if (!n_reset)   last_port <= 1'b1;
      else if (grant) last_port <= grant_port;
   end

   assign tie_port = ~last_port;
`else
   assign tie_port = 1'b0;
`endif

   // State and hold-counter register.
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         state <= IDLE;
         hold  <= 8'd0;
      end else begin
         state <= state_nx;
         hold  <= hold_nx;
      end
   end

   // Grant selection and next state; an owner change restarts the streak at 1.
   always_comb begin
      grant      = 1'b0;
      grant_port = 1'b0;
      state_nx   = IDLE;
      hold_nx    = 8'd0;
      case (state)
         OWN0: begin
            if (req0 && !(req1 && at_limit)) begin grant = 1'b1; grant_port = 1'b0; end
            else if (req1)                   begin grant = 1'b1; grant_port = 1'b1; end
         end
         OWN1: begin
            if (req1 && !(req0 && at_limit)) begin grant = 1'b1; grant_port = 1'b1; end
            else if (req0)                   begin grant = 1'b1; grant_port = 1'b0; end
         end
         default: begin
            if (req0 && req1) begin grant = 1'b1; grant_port = tie_port; end
            else if (req0)    begin grant = 1'b1; grant_port = 1'b0; end
            else if (req1)    begin grant = 1'b1; grant_port = 1'b1; end
         end
      endcase
      if (grant) begin
         state_nx = grant_port ? OWN1 : OWN0;
         hold_nx  = (state_nx == state) ? hold_inc : 8'd1;
      end
   end

   // Grant pulses and the registered RAM request; address/data hold when idle.
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         m_wren <= 1'b0;
         m_addr <= '0;
         m_data <= '0;
      end else begin
         gnt0   <= grant & ~grant_port;
         gnt1   <= grant &  grant_port;
         m_wren <= grant & sel.we;
         if (grant) begin
            m_addr <= sel.addr;
            m_data <= sel.wdata;
         end
      end
   end

   // Read return: capture m_q one edge after the grant, present it on the next.
   always_ff @(posedge clock) begin
      if (!n_reset) begin
         vld_pipe  <= '0;
         port_pipe <= '0;
         q_cap     <= '0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         vld_pipe  <= {vld_pipe[STAGES-1:1], rd_issue};
         port_pipe <= {port_pipe[STAGES-1:1], grant_port};
         if (vld_pipe[1]) q_cap <= m_q;
         rvalid0 <= vld_pipe[STAGES] & ~port_pipe[STAGES];
         rvalid1 <= vld_pipe[STAGES] &  port_pipe[STAGES];
         if (vld_pipe[STAGES] && !port_pipe[STAGES]) rdata0 <= q_cap;
         if (vld_pipe[STAGES] &&  port_pipe[STAGES]) rdata1 <= q_cap;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a falling-edge RAM model.
module tb_ram_arbiter;
   localparam int AW = 12;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          n_reset, req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1, m_addr;
   logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, m_data, m_q;
   logic          gnt0, gnt1, rvalid0, rvalid1, m_wren;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   int tests = 0;
   int fails = 0;

   ram_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(8)) dut (
      .clock(clock), .n_reset(n_reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .m_addr(m_addr), .m_data(m_data), .m_wren(m_wren), .m_q(m_q)
   );

   always #5 clock = ~clock;

   // RAM samples the request on the falling edge (read-before-write).
   always @(negedge clock) begin
      if (m_wren) mem[m_addr] <= m_data;
      m_q <= mem[m_addr];
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      n_reset = 1'b0;
      tick();
      tick();
      tests++;
      if ({gnt0, gnt1, rvalid0, rvalid1, m_wren} !== 5'b0) begin
         fails++; $display("FAIL reset_ctl: got %b want 00000", {gnt0, gnt1, rvalid0, rvalid1, m_wren});
      end
      tests++;
      if ({rdata0, rdata1, m_addr, m_data} !== '0) begin
         fails++; $display("FAIL reset_data: got %h %h %h %h want 0", rdata0, rdata1, m_addr, m_data);
      end
      n_reset = 1'b1;
      tick();
      tests++;
      if (m_wren !== 1'b0) begin fails++; $display("FAIL reset_nowrite: got %b want 0", m_wren); end
   endtask

   task automatic test_read();
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h005;
      tick();
      tests++;
      if ({gnt0, gnt1, m_wren} !== 3'b100 || m_addr !== 12'h005) begin
         fails++; $display("FAIL read_grant: got gnt=%b%b wren=%b addr=%h want 10 0 005", gnt0, gnt1, m_wren, m_addr);
      end
      req0 = 1'b0;
      tick();
      tests++;
      if (rvalid0 !== 1'b0 || m_wren !== 1'b0 || m_addr !== 12'h005 || gnt0 !== 1'b0) begin
         fails++; $display("FAIL read_idle: got rv=%b wren=%b addr=%h gnt=%b want 0 0 005 0", rvalid0, m_wren, m_addr, gnt0);
      end
      tick();
      tests++;
      if (rvalid0 !== 1'b1 || rdata0 !== 16'h1234 || rvalid1 !== 1'b0) begin
         fails++; $display("FAIL read_data: got rv0=%b rd0=%h rv1=%b want 1 1234 0", rvalid0, rdata0, rvalid1);
      end
      tick();
      tests++;
      if (rvalid0 !== 1'b0 || rdata0 !== 16'h1234) begin
         fails++; $display("FAIL read_hold: got rv0=%b rd0=%h want 0 1234", rvalid0, rdata0);
      end
   endtask

   task automatic test_write_read();
      logic seen1;
      req1 = 1'b1; we1 = 1'b1; addr1 = 12'h7FF; wdata1 = 16'hBEEF;
      tick();
      seen1 = rvalid1;
      tests++;
      if ({gnt0, gnt1, m_wren} !== 3'b011 || m_addr !== 12'h7FF || m_data !== 16'hBEEF) begin
         fails++; $display("FAIL wr_grant: got gnt=%b%b wren=%b addr=%h data=%h want 01 1 7ff beef", gnt0, gnt1, m_wren, m_addr, m_data);
      end
      req1 = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 12'h7FF;
      tick();
      seen1 |= rvalid1;
      tests++;
      if ({gnt0, gnt1, m_wren} !== 3'b100) begin
         fails++; $display("FAIL wr_rd_grant: got %b want 100", {gnt0, gnt1, m_wren});
      end
      req0 = 1'b0;
      tick();
      seen1 |= rvalid1;
      tick();
      seen1 |= rvalid1;
      tests++;
      if (rvalid0 !== 1'b1 || rdata0 !== 16'hBEEF) begin
         fails++; $display("FAIL wr_readback: got rv0=%b rd0=%h want 1 beef", rvalid0, rdata0);
      end
      tick();
      seen1 |= rvalid1;
      tests++;
      if (seen1 !== 1'b0) begin fails++; $display("FAIL wr_no_rvalid1: got %b want 0", seen1); end
   endtask

   task automatic test_contention();
      logic [1:0] exp_g, exp_r;
      n_reset = 1'b0;
      tick();
      n_reset = 1'b1;
      mem[12'h010] = 16'hA0A0;
      mem[12'h020] = 16'hB1B1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h020;
      for (int i = 0; i < 34; i++) begin
         if (i == 32) begin req0 = 1'b0; req1 = 1'b0; end
         tick();
         exp_g = 2'b00;
         if (i < 32) exp_g = ((i / 8) % 2 == 0) ? 2'b10 : 2'b01;
         exp_r = 2'b00;
         if (i >= 2) exp_r = (((i - 2) / 8) % 2 == 0) ? 2'b10 : 2'b01;
         tests++;
         if ({gnt0, gnt1} !== exp_g) begin
            fails++; $display("FAIL cont_gnt[%0d]: got %b want %b", i, {gnt0, gnt1}, exp_g);
         end
         tests++;
         if ({rvalid0, rvalid1} !== exp_r) begin
            fails++; $display("FAIL cont_rvalid[%0d]: got %b want %b", i, {rvalid0, rvalid1}, exp_r);
         end
         if (exp_r == 2'b10) begin
            tests++;
            if (rdata0 !== 16'hA0A0) begin fails++; $display("FAIL cont_rdata0[%0d]: got %h want a0a0", i, rdata0); end
         end
         if (exp_r == 2'b01) begin
            tests++;
            if (rdata1 !== 16'hB1B1) begin fails++; $display("FAIL cont_rdata1[%0d]: got %h want b1b1", i, rdata1); end
         end
      end
   endtask

   task automatic test_tie();
      logic [1:0] exp_g;
`ifdef RAM_ARB_ROUND_ROBIN_EN
      exp_g = 2'b01;
`else
      exp_g = 2'b10;
`endif
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h005;
      tick();
      tests++;
      if ({gnt0, gnt1} !== 2'b10) begin fails++; $display("FAIL tie_pre: got %b want 10", {gnt0, gnt1}); end
      req0 = 1'b0;
      tick();
      tests++;
      if ({gnt0, gnt1} !== 2'b00) begin fails++; $display("FAIL tie_idle: got %b want 00", {gnt0, gnt1}); end
      req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 12'h005;
      tick();
      tests++;
      if ({gnt0, gnt1} !== exp_g) begin fails++; $display("FAIL tie_pick: got %b want %b", {gnt0, gnt1}, exp_g); end
      req0 = 1'b0; req1 = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset_inflight();
      logic seen;
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h005;
      tick();
      tests++;
      if (gnt0 !== 1'b1) begin fails++; $display("FAIL rst_fl_grant: got %b want 1", gnt0); end
      req0 = 1'b0; n_reset = 1'b0;
      tick();
      tests++;
      if ({gnt0, gnt1, rvalid0, rvalid1, m_wren} !== 5'b0 || {rdata0, rdata1, m_addr, m_data} !== '0) begin
         fails++; $display("FAIL rst_fl_zero: got %b %h %h %h %h want all 0", {gnt0, gnt1, rvalid0, rvalid1, m_wren}, rdata0, rdata1, m_addr, m_data);
      end
      n_reset = 1'b1;
      seen = 1'b0;
      repeat (4) begin tick(); seen |= rvalid0 | rvalid1 | m_wren; end
      tests++;
      if (seen !== 1'b0) begin fails++; $display("FAIL rst_fl_norvalid: got %b want 0", seen); end
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h005;
      tick();
      tests++;
      if ({gnt0, gnt1} !== 2'b01) begin fails++; $display("FAIL rst_fl_regrant: got %b want 01", {gnt0, gnt1}); end
      req1 = 1'b0;
      tick();
      tick();
      tests++;
      if (rvalid1 !== 1'b1 || rdata1 !== 16'h1234) begin
         fails++; $display("FAIL rst_fl_read: got rv1=%b rd1=%h want 1 1234", rvalid1, rdata1);
      end
   endtask

   task automatic test_back_to_back();
      req0 = 1'b1; we0 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         addr0 = 12'(256 + i); wdata0 = 16'(i + 16'h5500);
         tick();
         tests++;
         if ({gnt0, gnt1, m_wren} !== 3'b101 || m_addr !== 12'(256 + i) || m_data !== 16'(i + 16'h5500)) begin
            fails++; $display("FAIL b2b[%0d]: got gnt=%b%b wren=%b addr=%h data=%h", i, gnt0, gnt1, m_wren, m_addr, m_data);
         end
      end
      req0 = 1'b0;
      tick();
      tests++;
      if ({gnt0, m_wren} !== 2'b00) begin fails++; $display("FAIL b2b_end: got %b want 00", {gnt0, m_wren}); end
   endtask

   initial begin
      n_reset = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
      mem[12'h005] = 16'h1234;
      test_reset();
      test_read();
      test_write_read();
      test_contention();
      test_tie();
      test_reset_inflight();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
